// File: rtl/stim_lcg_gen.sv
// LCG-driven stimulus engine: builds IN_W-bit vectors from a 32-bit LCG,
// hands them out over valid/ready and compacts DUT outputs into a MISR.
module stim_lcg_gen #(
  parameter int          IN_W  = 141,
  parameter int          OUT_W = 159,
  parameter logic [31:0] SEED  = 32'd1806341205
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic [31:0]      cycles,
  output logic [IN_W-1:0]  stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vec_count,
  output logic [31:0]      signature
);
  localparam int NW = (IN_W + 31) / 32;
  localparam int NO = (OUT_W + 31) / 32;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  // last word goes straight to stim_data, so only NW-1 slots are buffered
  localparam int SW = (NW > 1) ? NW - 1 : 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

  state_t                state, state_nxt;
  logic [31:0]           lcg, lcg_nxt, remaining;
  logic [IW-1:0]         idx;
  logic [SW-1:0][31:0]   shadow;
  logic [NO*32-1:0]      out_ext;
  logic [31:0]           fold, sig_nxt;
  logic                  accept, last_slot;

  assign lcg_nxt   = lcg * 32'h41C64E6D + 32'h3039;
  assign last_slot = (idx == IW'(NW - 1));
  assign accept    = (state == HOLD) && stim_valid && stim_ready && !abort;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    out_ext = '0;
    out_ext[OUT_W-1:0] = dut_out;
    fold = '0;
    for (int k = 0; k < NO; k++) fold = fold ^ out_ext[k*32 +: 32];
    sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!seed_load && start) state_nxt = (cycles == 32'd0) ? DONE : FILL;
      FILL: if (abort) state_nxt = IDLE;
            else if (last_slot) state_nxt = HOLD;
      HOLD: if (abort) state_nxt = IDLE;
            else if (accept) state_nxt = (remaining == 32'd1) ? DONE : FILL;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcg        <= SEED;
      remaining  <= '0;
      idx        <= '0;
      shadow     <= '0;
      stim_data  <= '0;
      stim_valid <= 1'b0;
      vec_count  <= '0;
      signature  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) lcg <= seed_in;
          else if (start) begin
            remaining <= cycles;
            vec_count <= '0;
            signature <= '0;
            idx       <= '0;
          end
        end
        FILL: begin
          if (!abort) begin
            lcg <= lcg_nxt;
            if (last_slot) begin
              // publish the whole vector at once; never a partial one
              if (NW > 1) stim_data <= IN_W'({lcg_nxt, shadow});
              else        stim_data <= IN_W'(lcg_nxt);
              stim_valid <= 1'b1;
            end else begin
              shadow[idx] <= lcg_nxt;
              idx         <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (abort) stim_valid <= 1'b0;
          else if (accept) begin
            signature  <= sig_nxt;
            vec_count  <= vec_count + 32'd1;
            remaining  <= remaining - 32'd1;
            stim_valid <= 1'b0;
            idx        <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stim_lcg_gen.sv
// Directed/randomized bench for stim_lcg_gen against a software LCG/MISR model.
module tb_stim_lcg_gen;
  localparam int          IN_W  = 141;
  localparam int          OUT_W = 159;
  localparam logic [31:0] SEED  = 32'd1806341205;
  localparam int          NW    = (IN_W + 31) / 32;

  logic clk = 0, rst_n, start, abort, seed_load, stim_ready;
  logic [31:0] seed_in, cycles, vec_count, signature;
  logic [IN_W-1:0] stim_data;
  logic [OUT_W-1:0] dut_out;
  logic stim_valid, busy, done;

  int checks = 0, errors = 0;
  logic [31:0] m_lcg, m_sig, m_cnt;
  logic [IN_W-1:0] exp_vec;

  stim_lcg_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_load(seed_load),
    .seed_in(seed_in), .cycles(cycles), .stim_data(stim_data), .stim_valid(stim_valid),
    .stim_ready(stim_ready), .dut_out(dut_out), .busy(busy), .done(done),
    .vec_count(vec_count), .signature(signature));

  always #5 clk = ~clk;

  function automatic logic [31:0] lcg_f(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  function automatic logic [31:0] misr_f(input logic [31:0] s, input logic [OUT_W-1:0] o);
    logic [31:0] f = '0;
    for (int j = 0; j < OUT_W; j++) f[j % 32] = f[j % 32] ^ o[j];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_out();
    for (int i = 0; i < (OUT_W + 31) / 32; i++) dut_out = (dut_out << 32) | OUT_W'($urandom());
  endtask

  task automatic do_start(input logic [31:0] n);
    cycles = n; start = 1; tick(); start = 0;
    m_cnt = 0; m_sig = 0;
    chk("start_busy", 192'(busy), 192'(1'b1));
    chk("start_cnt_clr", 192'(vec_count), 192'(m_cnt));
  endtask

  // fill phase: NW LCG steps, optional ignored start/seed_load poke
  task automatic get_vec(input bit poke);
    logic [NW*32-1:0] w;
    w = '0;
    for (int k = 0; k < NW; k++) begin
      m_lcg = lcg_f(m_lcg);
      w[k*32 +: 32] = m_lcg;
      if (poke && k == 0) begin
        start = 1; seed_load = 1; seed_in = $urandom(); cycles = $urandom();
      end
      tick();
      start = 0; seed_load = 0;
      if (k == NW - 2) chk("valid_early", 192'(stim_valid), 192'(1'b0));
    end
    exp_vec = w[IN_W-1:0];
    chk("valid_up", 192'(stim_valid), 192'(1'b1));
    chk("stim_data", 192'(stim_data), 192'(exp_vec));
  endtask

  task automatic accept(input int hold, input bit last);
    repeat (hold) begin
      tick();
      chk("bp_valid", 192'(stim_valid), 192'(1'b1));
      chk("bp_data", 192'(stim_data), 192'(exp_vec));
      chk("bp_cnt", 192'(vec_count), 192'(m_cnt));
    end
    rand_out(); stim_ready = 1; tick(); stim_ready = 0;
    m_sig = misr_f(m_sig, dut_out); m_cnt++;
    chk("acc_valid", 192'(stim_valid), 192'(1'b0));
    chk("acc_cnt", 192'(vec_count), 192'(m_cnt));
    chk("acc_sig", 192'(signature), 192'(m_sig));
    chk("acc_done", 192'(done), 192'(last));
    if (last) begin
      chk("done_busy", 192'(busy), 192'(1'b1));
      tick();
      chk("done_drop", 192'(done), 192'(1'b0));
      chk("busy_drop", 192'(busy), 192'(1'b0));
    end
  endtask

  task automatic run(input int n, input int maxhold);
    do_start(n);
    for (int v = 0; v < n; v++) begin
      get_vec(v == 1);
      accept($urandom_range(0, maxhold), v == n - 1);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_data", 192'(stim_data), 192'(0));
    chk("rst_valid", 192'(stim_valid), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_cnt", 192'(vec_count), 192'(0));
    chk("rst_sig", 192'(signature), 192'(0));
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; seed_load = 0; stim_ready = 0;
    seed_in = 0; cycles = 0; dut_out = '0;
    m_lcg = SEED; m_sig = 0; m_cnt = 0; exp_vec = '0;
    tick(); tick();
    chk_reset_vals();
    rst_n = 1;

    // default seed cross-check
    run(3, 0);

    // seed_load beats start in IDLE; 40-bit packing from seed 0
    seed_load = 1; seed_in = 0; start = 1; cycles = 9; tick();
    seed_load = 0; start = 0;
    chk("seed_no_start", 192'(busy), 192'(1'b0));
    m_lcg = 0;
    do_start(1);
    get_vec(0);
    chk("pack40", 192'(stim_data[39:0]), 192'(40'h7E00003039));
    accept(0, 1);

    // longer run with random back-pressure, one 7-cycle stall
    do_start(12);
    for (int v = 0; v < 12; v++) begin
      get_vec(v == 2);
      accept((v == 4) ? 7 : $urandom_range(0, 3), v == 11);
    end

    // cycles == 0
    cycles = 0; start = 1; tick(); start = 0;
    m_sig = 0; m_cnt = 0;
    chk("zero_done", 192'(done), 192'(1'b1));
    chk("zero_sig", 192'(signature), 192'(0));
    chk("zero_cnt", 192'(vec_count), 192'(0));
    tick();
    chk("zero_idle", 192'(busy), 192'(1'b0));
    run(2, 1);

    // abort during FILL after one accepted vector
    do_start(5);
    get_vec(0);
    accept(1, 0);
    m_lcg = lcg_f(lcg_f(m_lcg));
    tick(); tick();
    abort = 1; tick(); abort = 0;
    chk("abf_busy", 192'(busy), 192'(0));
    chk("abf_valid", 192'(stim_valid), 192'(0));
    chk("abf_done", 192'(done), 192'(0));
    chk("abf_cnt", 192'(vec_count), 192'(m_cnt));
    chk("abf_sig", 192'(signature), 192'(m_sig));
    tick();
    chk("abf_nodone", 192'(done), 192'(0));

    // abort coinciding with accept in HOLD
    do_start(4);
    get_vec(0);
    accept(0, 0);
    get_vec(0);
    rand_out(); stim_ready = 1; abort = 1; tick(); stim_ready = 0; abort = 0;
    chk("aba_busy", 192'(busy), 192'(0));
    chk("aba_valid", 192'(stim_valid), 192'(0));
    chk("aba_done", 192'(done), 192'(0));
    chk("aba_cnt", 192'(vec_count), 192'(m_cnt));
    chk("aba_sig", 192'(signature), 192'(m_sig));
    run(2, 2);

    // reset while a vector is valid
    do_start(3);
    get_vec(0);
    stim_ready = 1; abort = 1; rst_n = 0; tick(); stim_ready = 0; abort = 0;
    chk_reset_vals();
    rst_n = 1;
    m_lcg = SEED;
    run(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
